// File: rtl/dmem_lsu_pkg.sv
// Shared constants for the data-memory load/store unit: funct3 encodings, FSM states,
// the latched request record and the default memory base address.
package dmem_lsu_pkg;

    localparam logic [31:0] MEM_BASE_DEFAULT = 32'h0100_0000;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        StIdle,
        StWait
    } lsu_state_e;

    typedef struct packed {
        logic        we;
        logic [2:0]  funct3;
        logic [31:0] addr;
        logic [31:0] wdata;
    } lsu_req_t;

endpackage

// File: rtl/dmem_lsu_if.sv
// Request/response bus between the core (master) and the load/store unit (slave).
interface dmem_lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: load extraction/extension, store byte enables and data
// replication, plus alignment and funct3 legality flags.
module lsu_align
    import dmem_lsu_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [31:0] ld_data,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic        align_err
);
    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    assign rbyte = rword[{addr_lo, 3'b000} +: 8];
    assign rhalf = addr_lo[1] ? rword[31:16] : rword[15:0];

    always_comb begin
        ld_data   = '0;
        be        = '0;
        wdata_rep = '0;
        align_err = 1'b0;
        if (we) begin
            unique case (funct3)
                F3_B: begin
                    be        = 4'b0001 << addr_lo;
                    wdata_rep = {4{wdata[7:0]}};
                end
                F3_H: begin
                    align_err = addr_lo[0];
                    be        = addr_lo[1] ? 4'b1100 : 4'b0011;
                    wdata_rep = {2{wdata[15:0]}};
                end
                F3_W: begin
                    align_err = (addr_lo != 2'b00);
                    be        = 4'b1111;
                    wdata_rep = wdata;
                end
                default: align_err = 1'b1;
            endcase
        end else begin
            unique case (funct3)
                F3_B:  ld_data = {{24{rbyte[7]}}, rbyte};
                F3_BU: ld_data = {24'h0, rbyte};
                F3_H: begin
                    align_err = addr_lo[0];
                    ld_data   = {{16{rhalf[15]}}, rhalf};
                end
                F3_HU: begin
                    align_err = addr_lo[0];
                    ld_data   = {16'h0, rhalf};
                end
                F3_W: begin
                    align_err = (addr_lo != 2'b00);
                    ld_data   = rword;
                end
                default: align_err = 1'b1;
            endcase
        end
        if (align_err) begin
            ld_data = '0;
            be      = '0;
        end
    end
endmodule

// File: rtl/dmem_lsu.sv
// Data-memory load/store unit: valid/ready request, programmable access latency,
// byte-addressable word array with sized, sign/zero-extended accesses.
module dmem_lsu
    import dmem_lsu_pkg::*;
#(
    parameter logic [31:0] MEM_BASE    = MEM_BASE_DEFAULT,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 1
) (
    input logic        clk,
    input logic        rst_n,
    dmem_lsu_if.slave  bus
);
    localparam int unsigned IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [31:0] MEM_BYTES = 32'(4 * DEPTH_WORDS);

    lsu_state_e  state_q;
    logic [2:0]  cnt_q;
    lsu_req_t    req_q;
    logic        resp_valid_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic [31:0] offset;
    logic        range_err;
    logic [IDX_W-1:0] idx;
    logic [31:0] rword;
    logic [31:0] ld_data;
    logic [3:0]  be;
    logic [31:0] wdata_rep;
    logic        align_err;
    logic        err;
    logic        done;

    // An address below the base wraps to a huge offset, but is rejected explicitly anyway.
    assign offset    = req_q.addr - MEM_BASE;
    assign range_err = (req_q.addr < MEM_BASE) || (offset >= MEM_BYTES);
    assign idx       = offset[IDX_W+1:2];
    assign rword     = mem[idx];
    assign err       = range_err | align_err;
    assign done      = (state_q == StWait) && (cnt_q == 3'd0);

    lsu_align u_align (
        .we        (req_q.we),
        .funct3    (req_q.funct3),
        .addr_lo   (req_q.addr[1:0]),
        .wdata     (req_q.wdata),
        .rword     (rword),
        .ld_data   (ld_data),
        .be        (be),
        .wdata_rep (wdata_rep),
        .align_err (align_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            req_q        <= '0;
            resp_valid_q <= 1'b0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            resp_valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.req_valid) begin
                        req_q   <= '{we: bus.req_we, funct3: bus.req_funct3,
                                     addr: bus.req_addr, wdata: bus.req_wdata};
                        cnt_q   <= 3'(LATENCY - 1);
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    if (cnt_q != 3'd0) begin
                        cnt_q <= cnt_q - 3'd1;
                    end else begin
                        resp_valid_q <= 1'b1;
                        rdata_q      <= (err || req_q.we) ? 32'h0 : ld_data;
                        err_q        <= err;
                        state_q      <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Reset forces state_q to StIdle asynchronously, so a pending store can never commit.
    always_ff @(posedge clk) begin
        if (done && !err) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[idx][8*b +: 8] <= wdata_rep[8*b +: 8];
            end
        end
    end

    assign bus.req_ready  = (state_q == StIdle);
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;
endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
Data-memory load/store unit for the single-cycle RV32I core. It fills the dmem slot of the write-back mux, which is currently tied to zero.
- Request side: address from ALU_out, store data from data_rs2, funct3 and MemRW from decode.
- Storage: an internal byte-addressable word array.
- Sizing and alignment: handles byte/halfword/word sizing, sign/zero extension, byte-lane stores and misalignment/range errors.
- Timing: a valid/ready request handshake and a programmable access latency, so the core can later stall on memory.

Parameters:
MEM_BASE, 32'h01000000, byte address of word 0 (unified with instruction space).
DEPTH_WORDS, 1024, number of 32-bit words; legal range MEM_BASE .. MEM_BASE+4*DEPTH_WORDS-1.
LATENCY, 1, cycles from acceptance to response; legal 1..7.

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  unit can accept; high only in IDLE
req_we  in  1  1=store, 0=load (MemRW)
req_funct3  in  3  RV32I load/store funct3
req_addr  in  32  byte address (ALU_out)
req_wdata  in  32  store data (data_rs2)
resp_valid  out  1  one-cycle pulse, response valid
resp_rdata  out  32  formatted load data; 0 for stores and errors
resp_err  out  1  misaligned, out-of-range or illegal funct3; qualified by resp_valid

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, counter=0, resp_valid=0, resp_rdata=0, resp_err=0, latched request cleared.
  - req_ready=1 once in IDLE.
  - Memory array is NOT reset; contents persist across reset.
- Acceptance:
  - A request is accepted on a rising edge with req_valid&&req_ready.
  - addr, we, funct3 and wdata are latched at that edge; later input changes are ignored.
- FSM IDLE:
  - On accept, set cnt<=LATENCY-1 and go to WAIT.
- FSM WAIT:
  - If cnt!=0, cnt<=cnt-1.
  - If cnt==0, perform the access, register resp_*, pulse resp_valid, go to IDLE.
- Latency:
  - Accept at edge N gives resp_valid high for exactly the cycle after edge N+LATENCY.
  - req_ready is low from edge N+1 until the response edge.
- Back-to-back:
  - In the resp_valid cycle the unit is in IDLE with req_ready=1, so a new request may be accepted on that edge.
  - resp_valid deasserts on the next edge unless another response completes there.
- Load formatting, funct3 to byte lane selected by addr[1:0]:
  - 000 LB: sign-extend byte.
  - 001 LH: sign-extend half.
  - 010 LW: word.
  - 100 LBU: zero-extend byte.
  - 101 LHU: zero-extend half.
- Store, little-endian byte lanes:
  - 000 SB: write wdata[7:0] to lane addr[1:0].
  - 001 SH: write wdata[15:0] to lanes {addr[1],0}+1:0.
  - 010 SW: full word.
  - Non-selected lanes are unchanged.
  - The write commits on the response edge, so a following load always sees it.
- Errors (resp_err=1, no array write, resp_rdata=0, full latency still observed):
  - Halfword with addr[0]=1; word with addr[1:0]!=0.
  - Address below MEM_BASE or at/above MEM_BASE+4*DEPTH_WORDS. Offset subtraction is done in 32 bits with no wrap-around acceptance.
  - Load funct3 in {011,110,111}; store funct3 not in {000,001,010}.
- Word index is (addr-MEM_BASE)>>2.
- Reset asserted mid-operation:
  - Pending request dropped; no write occurs, no response, returns to IDLE.
- req_valid while not ready: ignored; the requester must hold it.

Decomposition:
- Shared constants file (alongside existing ALU/WB selects): funct3 load/store encodings, FSM state encodings (IDLE, WAIT), MEM_BASE default.
- One natural sub-module: lsu_align. It is purely combinational: load extraction/extension, store byte-enable and data replication, and alignment/funct3 error flags.
- The FSM, counter and array stay in dmem_lsu.

Test Plan:
1. Reset then SW 0xDEADBEEF @0x01000010, LATENCY=1 -> resp_valid pulse one cycle after accept, err=0; then LW @0x01000010 -> rdata=0xDEADBEEF.
2. After test 1:
   - LB @0x01000013 -> 0xFFFFFFDE.
   - LBU @0x01000013 -> 0x000000DE.
   - LH @0x01000010 -> 0xFFFFBEEF.
   - LHU @0x01000012 -> 0x0000DEAD.
3. SB 0x12 @0x01000011 over 0xDEADBEEF, then LW -> 0xDEAD12EF; SH 0x3456 @0x01000012 -> LW 0x345612EF.
4. Errors, each with err=1 and rdata=0, no write:
   - LW @0x01000002.
   - LH @0x01000001.
   - SW @0x00FFFFFC.
   - LW @MEM_BASE+4*DEPTH_WORDS.
   - Load funct3=011.
   - A subsequent LW of an untouched word confirms the failed stores wrote nothing.
5. LATENCY=4, req_valid held high continuously:
   - req_ready low for 4 cycles after each accept; resp_valid exactly 4 cycles after accept.
   - Second request accepted on the response edge.
   - wdata changed after accept has no effect.
6. LATENCY=4, SW accepted, rst_n pulsed low 2 cycles later:
   - No resp_valid, outputs 0, req_ready=1 after release.
   - LW of that address returns the pre-store value.
